// File: rtl/vid_mon_pkg.sv
// ============================================================================
// Module   : vid_mon_pkg
// Purpose  : Shared constants and FSM encoding for the video timing monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vid_mon_pkg;

    localparam int c_CNT_W_DEF    = 12;
    localparam int c_UF_CNT_W_DEF = 8;
    localparam int c_PIX_W        = 24;

    // Avalon-MM word addresses of the snapshot registers
    localparam logic [2:0] c_ADDR_GEOM   = 3'd0;
    localparam logic [2:0] c_ADDR_TOTAL  = 3'd1;
    localparam logic [2:0] c_ADDR_FRAMES = 3'd2;
    localparam logic [2:0] c_ADDR_UF     = 3'd3;
    localparam logic [2:0] c_ADDR_SIG    = 3'd4;
    localparam logic [2:0] c_ADDR_STATUS = 3'd5;

    typedef enum logic [0:0] {
        S_WAIT    = 1'b0,
        S_MEASURE = 1'b1
    } mon_state_t;

endpackage

`default_nettype wire

// File: rtl/vid_sat_cnt.sv
// ============================================================================
// Module   : vid_sat_cnt
// Purpose  : Saturating up-counter; clear and increment in one cycle loads 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vid_sat_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] c_ONE = W'(1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_base;

    assign w_base = i_clr ? '0 : r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_inc && (w_base != '1)) begin
            r_cnt <= w_base + c_ONE;
        end else begin
            r_cnt <= w_base;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/vid_timing_monitor.sv
// ============================================================================
// Module   : vid_timing_monitor
// Purpose  : Passive per-frame timing/geometry/signature monitor with an
//            Avalon-MM read slave publishing one snapshot per frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vid_timing_monitor
    import vid_mon_pkg::*;
#(
    parameter int CNT_W       = c_CNT_W_DEF,
    parameter bit SYNC_ACT_HI = 1'b0,
    parameter int UF_CNT_W    = c_UF_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [c_PIX_W-1:0]  vid_data,
    input  logic                vid_datavalid,
    input  logic                vid_h_sync,
    input  logic                vid_v_sync,
    input  logic                vid_underflow,
    input  logic [2:0]          avs_address,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    output logic                stats_valid,
    output logic                timing_stable
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    // Input register stage; sync levels stored already normalised to "active"
    logic [c_PIX_W-1:0] r_data;
    logic               r_dv;
    logic               r_uf;
    logic               r_hs_act;
    logic               r_vs_act;
    logic               r_hs_act_d;
    logic               r_vs_act_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data     <= '0;
            r_dv       <= 1'b0;
            r_uf       <= 1'b0;
            r_hs_act   <= 1'b0;
            r_vs_act   <= 1'b0;
            r_hs_act_d <= 1'b0;
            r_vs_act_d <= 1'b0;
        end else begin
            r_data     <= vid_data;
            r_dv       <= vid_datavalid;
            r_uf       <= vid_underflow;
            r_hs_act   <= (vid_h_sync == SYNC_ACT_HI);
            r_vs_act   <= (vid_v_sync == SYNC_ACT_HI);
            r_hs_act_d <= r_hs_act;
            r_vs_act_d <= r_vs_act;
        end
    end

    logic w_h_edge;
    logic w_v_edge;

    assign w_h_edge = r_hs_act & ~r_hs_act_d;
    assign w_v_edge = r_vs_act & ~r_vs_act_d;

    // Running counters
    logic [CNT_W-1:0]    w_hcnt;
    logic [CNT_W-1:0]    w_wcnt;
    logic [CNT_W-1:0]    w_lcnt;
    logic [CNT_W-1:0]    w_act;
    logic [UF_CNT_W-1:0] w_uf;
    logic                w_wcnt_nz;

    assign w_wcnt_nz = (w_wcnt != '0);

    vid_sat_cnt #(.W(CNT_W)) u_hcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_h_edge | w_v_edge),
        .i_inc   (1'b1),
        .o_cnt   (w_hcnt)
    );

    vid_sat_cnt #(.W(CNT_W)) u_wcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_h_edge | w_v_edge),
        .i_inc   (r_dv),
        .o_cnt   (w_wcnt)
    );

    // A line edge coinciding with the frame edge is credited to the old frame
    // through the *_fin terms below, not to the new frame's counters.
    vid_sat_cnt #(.W(CNT_W)) u_lcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_v_edge),
        .i_inc   (w_h_edge & ~w_v_edge),
        .o_cnt   (w_lcnt)
    );

    vid_sat_cnt #(.W(CNT_W)) u_act_lines (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_v_edge),
        .i_inc   (w_h_edge & w_wcnt_nz & ~w_v_edge),
        .o_cnt   (w_act)
    );

    vid_sat_cnt #(.W(UF_CNT_W)) u_uf_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_v_edge),
        .i_inc   (r_uf),
        .o_cnt   (w_uf)
    );

    // Per-frame latched line measurements and signature
    logic [CNT_W-1:0]   r_htotal_run;
    logic [CNT_W-1:0]   r_width_run;
    logic [c_PIX_W-1:0] r_sig_run;

    logic [CNT_W-1:0]   w_htotal_fin;
    logic [CNT_W-1:0]   w_width_fin;
    logic [CNT_W-1:0]   w_vtotal_fin;
    logic [CNT_W-1:0]   w_height_fin;

    // Once a latched value has saturated it is frozen for the rest of the frame
    assign w_htotal_fin = (w_h_edge && (r_htotal_run != '1)) ? w_hcnt : r_htotal_run;
    assign w_width_fin  = (w_h_edge && w_wcnt_nz && (r_width_run != '1)) ? w_wcnt : r_width_run;
    assign w_vtotal_fin = (w_h_edge && (w_lcnt != '1)) ? (w_lcnt + c_ONE) : w_lcnt;
    assign w_height_fin = (w_h_edge && w_wcnt_nz && (w_act != '1)) ? (w_act + c_ONE) : w_act;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_htotal_run <= '0;
            r_width_run  <= '0;
            r_sig_run    <= '0;
        end else if (w_v_edge) begin
            r_htotal_run <= '0;
            r_width_run  <= '0;
            r_sig_run    <= r_dv ? r_data : '0;
        end else begin
            r_htotal_run <= w_htotal_fin;
            r_width_run  <= w_width_fin;
            if (r_dv) begin
                r_sig_run <= r_sig_run ^ r_data;
            end
        end
    end

    // FSM and snapshot registers
    mon_state_t          r_state;
    logic [CNT_W-1:0]    r_width;
    logic [CNT_W-1:0]    r_height;
    logic [CNT_W-1:0]    r_htotal;
    logic [CNT_W-1:0]    r_vtotal;
    logic [UF_CNT_W-1:0] r_uf_snap;
    logic [c_PIX_W-1:0]  r_sig_snap;
    logic [31:0]         r_frame_cnt;
    logic                r_stats_valid;
    logic                r_timing_stable;
    logic                r_sticky_uf;

    logic w_publish;
    logic w_rd_status;
    logic w_same_geom;

    assign w_publish   = w_v_edge && (r_state == S_MEASURE);
    assign w_rd_status = avs_read && (avs_address == c_ADDR_STATUS);
    assign w_same_geom = (w_width_fin  == r_width)  && (w_height_fin == r_height) &&
                         (w_htotal_fin == r_htotal) && (w_vtotal_fin == r_vtotal);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= S_WAIT;
            r_width         <= '0;
            r_height        <= '0;
            r_htotal        <= '0;
            r_vtotal        <= '0;
            r_uf_snap       <= '0;
            r_sig_snap      <= '0;
            r_frame_cnt     <= '0;
            r_stats_valid   <= 1'b0;
            r_timing_stable <= 1'b0;
            r_sticky_uf     <= 1'b0;
        end else begin
            r_stats_valid <= 1'b0;
            // Set beats a same-cycle status read
            r_sticky_uf   <= (w_publish && (w_uf != '0)) | (r_sticky_uf & ~w_rd_status);
            case (r_state)
                S_WAIT: begin
                    if (w_v_edge) begin
                        r_state <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (w_v_edge) begin
                        r_width         <= w_width_fin;
                        r_height        <= w_height_fin;
                        r_htotal        <= w_htotal_fin;
                        r_vtotal        <= w_vtotal_fin;
                        r_uf_snap       <= w_uf;
                        r_sig_snap      <= r_sig_run;
                        r_frame_cnt     <= r_frame_cnt + 32'd1;
                        r_stats_valid   <= 1'b1;
                        r_timing_stable <= w_same_geom;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                end
            endcase
        end
    end

    // Read mux; fields are zero-extended into the 32-bit word
    logic [31:0] w_rd;
    logic [31:0] r_readdata;

    always_comb begin
        w_rd = '0;
        case (avs_address)
            c_ADDR_GEOM:   w_rd[2*CNT_W-1:0] = {r_height, r_width};
            c_ADDR_TOTAL:  w_rd[2*CNT_W-1:0] = {r_vtotal, r_htotal};
            c_ADDR_FRAMES: w_rd              = r_frame_cnt;
            c_ADDR_UF:     w_rd[UF_CNT_W-1:0] = r_uf_snap;
            c_ADDR_SIG:    w_rd[c_PIX_W-1:0] = r_sig_snap;
            c_ADDR_STATUS: w_rd[1:0]         = {r_sticky_uf, r_timing_stable};
            default:       w_rd              = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= avs_read ? w_rd : 32'd0;
        end
    end

    assign avs_readdata  = r_readdata;
    assign stats_valid   = r_stats_valid;
    assign timing_stable = r_timing_stable;

endmodule

`default_nettype wire
